// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction-memory word address, captures
// the returned word and presents {instr, instr_pc} to decode with valid/ready.
module instr_fetch #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       rd,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fault,
  output logic [31:0]       fault_pc
);

  localparam int unsigned PC_W = ADDR_W + 2;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]      state, state_n;
  logic [31:0]     pc, pc_n;
  logic [31:0]     instr_n, instr_pc_n, fault_pc_n;
  logic            instr_valid_n, fault_n;
  logic [PC_W-1:0] pc_inc_c;
  logic [31:0]     pc_seq_c;
  logic            redirect_legal_c;

  assign address = pc[PC_W-1:2];

  // Sequential PC wraps within the memory's byte range.
  assign pc_inc_c = pc[PC_W-1:0] + PC_W'(4);
  assign pc_seq_c = 32'(pc_inc_c);

  assign redirect_legal_c = (redirect_pc[1:0] == 2'b00) &&
                            (redirect_pc[31:PC_W] == '0);

  // Next-state and datapath updates; redirect has priority over capture.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    fault_n       = fault;
    fault_pc_n    = fault_pc;
    case (state)
      ST_BOOT: begin
        if (redirect_valid && !redirect_legal_c) begin
          state_n    = ST_FAULT;
          fault_n    = 1'b1;
          fault_pc_n = redirect_pc;
        end else begin
          state_n = ST_RUN;
          if (redirect_valid) pc_n = redirect_pc;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          instr_valid_n = 1'b0;
          if (redirect_legal_c) begin
            pc_n = redirect_pc;
          end else begin
            state_n    = ST_FAULT;
            fault_n    = 1'b1;
            fault_pc_n = redirect_pc;
          end
        end else if (!instr_valid || instr_ready) begin
          instr_n       = rd;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          pc_n          = pc_seq_c;
        end
      end
      ST_FAULT: begin
        instr_valid_n = 1'b0;
      end
      default: begin
        state_n       = ST_FAULT;
        instr_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      fault       <= fault_n;
      fault_pc    <= fault_pc_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {instr, pc} pairs are queued by the
// stimulus and retired by a monitor on each decode handshake.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic [31:0]       rd;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              fault;
  logic [31:0]       fault_pc;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .rd            (rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory model: word k holds 0x01234560 + k.
  assign rd = 32'h0123_4560 + 32'(address);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push_w(input int k);
    exp_t e;
    e.instr = 32'h0123_4560 + 32'(k);
    e.pc    = 32'(k * 4);
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Retire one expected entry per accepted instruction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", instr_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    tick(2);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_address", 32'(address), 32'h0);

    // Boot and stream three words
    push_w(0); push_w(1); push_w(2);
    rst_n = 1'b1;
    tick(1);
    chk("boot_valid", 32'(instr_valid), 32'h0);
    tick(1);
    chk("first_valid", 32'(instr_valid), 32'h1);
    tick(2);

    // Backpressure while word 2 is presented
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_instr", instr, 32'h0123_4562);
      chk("hold_pc", instr_pc, 32'h8);
      chk("hold_address", 32'(address), 32'h3);
      tick(1);
    end
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    chk("resume_instr", instr, 32'h0123_4563);
    chk("resume_pc", instr_pc, 32'hC);

    // Redirect over a held instruction drops it
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(instr_valid), 32'h0);
    chk("redir_address", 32'(address), 32'd16);
    tick(1);
    chk("redir_tgt_valid", 32'(instr_valid), 32'h1);
    chk("redir_tgt_instr", instr, 32'h0123_4570);
    chk("redir_tgt_pc", instr_pc, 32'h40);

    // Redirect with ready=1 consumes word 16, then wrap from 0x78
    push_w(16);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h78;
    tick(1);
    redirect_valid = 1'b0;
    push_w(30); push_w(31); push_w(0); push_w(1);
    tick(5);
    instr_ready = 1'b0;
    chk("wrap_fault", 32'(fault), 32'h0);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    chk("wrap_next_pc", instr_pc, 32'h8);

    // Misaligned redirect faults; later legal redirects are ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick(1);
    chk("ill_fault", 32'(fault), 32'h1);
    chk("ill_fault_pc", fault_pc, 32'h42);
    chk("ill_valid", 32'(instr_valid), 32'h0);
    chk("ill_address", 32'(address), 32'h3);
    redirect_pc = 32'h40;
    instr_ready = 1'b1;
    tick(2);
    redirect_valid = 1'b0;
    chk("sticky_fault", 32'(fault), 32'h1);
    chk("sticky_fault_pc", fault_pc, 32'h42);
    chk("sticky_valid", 32'(instr_valid), 32'h0);
    chk("sticky_address", 32'(address), 32'h3);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_address", 32'(address), 32'h0);
    chk("arst_fault", 32'(fault), 32'h0);

    // Out-of-range redirect faults
    instr_ready = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("oor_pre_instr", instr, 32'h0123_4560);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick(1);
    redirect_valid = 1'b0;
    chk("oor_fault", 32'(fault), 32'h1);
    chk("oor_fault_pc", fault_pc, 32'h80);
    chk("oor_valid", 32'(instr_valid), 32'h0);
    tick(2);
    chk("oor_sticky", 32'(fault), 32'h1);
    chk("sb_final", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that drives the instruction memory's 5-bit word `address` and captures the returned 32-bit `rd` word.
- Holds the PC and registers {instruction, PC} toward decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and raises a sticky fault on an illegal redirect target.
- Sits between the PC/redirect logic and the decode stage of the single-issue RISC-V core.

Parameters:
- ADDR_W, 5, instruction memory word-address width (memory depth = 2^ADDR_W words).
- RESET_PC, 32'h00000000, byte address fetched first after reset; must be word-aligned and in range.
- NOP_INSTR, 32'h00000013, value driven on `instr` while no instruction has been captured (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- address  output  ADDR_W  word address to instruction memory; combinational = pc[ADDR_W+1:2].
- rd  input  32  instruction word from memory; combinational, valid in the same cycle as `address`.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  32  byte target of the redirect.
- instr  output  32  captured instruction to decode.
- instr_pc  output  32  byte PC of `instr`.
- instr_valid  output  1  `instr`/`instr_pc` hold a valid fetch.
- instr_ready  input  1  decode accepts the current instruction this cycle.
- fault  output  1  sticky illegal-redirect flag.
- fault_pc  output  32  offending redirect target.

Behaviour:
- Reset (async, rst_n=0), all values forced immediately:
  - pc=RESET_PC, state=BOOT
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0
  - fault=0, fault_pc=0
- States: BOOT, RUN, FAULT.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts; nothing is captured, instr_valid stays 0.
  - Next state is RUN.
  - A legal redirect in BOOT loads pc=redirect_pc and goes to RUN.
  - An illegal redirect in BOOT goes to FAULT.
- RUN, capture rule (no redirect):
  - Load condition: instr_valid==0 or instr_ready==1.
  - On load: instr<=rd, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
  - Otherwise pc, instr, instr_pc and instr_valid hold.
  - Steady-state throughput with instr_ready=1 is one instruction per cycle.
  - Fetch latency is one cycle: the word at `address` in cycle N appears on `instr` in cycle N+1.
- Sequential wrap: pc+4 is computed modulo 2^(ADDR_W+2). After the word at 4*(2^ADDR_W-1) is captured, pc becomes 0. This is not a fault.
- RUN, redirect (priority over capture):
  - Legality: target is legal iff redirect_pc[1:0]==0 and redirect_pc[31:ADDR_W+2]==0.
  - Legal target: pc<=redirect_pc and instr_valid<=0 (flush), regardless of instr_ready. instr/instr_pc keep their old values and nothing is captured that cycle.
  - Legal target timing: a redirect sampled in cycle N gives address=target in N+1, and the target instruction is valid in N+2 (2-cycle penalty).
  - Illegal target: state<=FAULT, fault<=1, fault_pc<=redirect_pc, instr_valid<=0; pc unchanged.
- FAULT:
  - Terminal until reset; no captures, instr_valid=0.
  - redirect_valid and instr_ready are ignored; fault and fault_pc hold.
  - `address` continues to reflect the frozen pc.
- Simultaneous events:
  - redirect_valid with instr_valid=1 and instr_ready=0: the held instruction is dropped.
  - redirect_valid with instr_ready=1: decode consumes the current instr in that cycle, and no new one is captured.
- Reset mid-operation: any state returns immediately to reset values. An instruction in flight is lost.
- `address` is never X after reset; pc changes only at clock edges or on async reset.

Test Plan:
- Reset, memory word k = 32'h01234560+k, instr_ready=1 held -> instr_valid rises 2 cycles after rst_n deasserts. Then instr = 32'h01234560, 32'h01234561, 32'h01234562 on consecutive cycles with instr_pc = 0, 4, 8.
- Backpressure: instr_ready=0 for 3 cycles while instr=32'h01234562 -> instr, instr_pc=8 and address=3 stay stable. When ready returns, the next instr is 32'h01234563 with no skipped or duplicated word.
- Redirect: redirect_valid=1, redirect_pc=32'h40 in cycle N while instr_valid=1 and ready=0 -> instr_valid=0 in N+1 with address=16. In N+2, instr = word 16, instr_pc=32'h40, instr_valid=1.
- Wrap: run from RESET_PC=32'h78 -> instr_pc sequence 32'h78, 32'h7C, 32'h00, 32'h04, with fault staying 0.
- Illegal redirect: redirect_pc=32'h42, and separately 32'h80 -> fault=1 next cycle with fault_pc equal to the target and instr_valid=0. Fault stays latched through later legal redirects, and only rst_n=0 clears it.
- Async reset mid-stream: assert rst_n=0 between clock edges -> instr_valid=0, instr=32'h00000013 and address=RESET_PC[6:2] without waiting for a clock edge.
